pipe_trace_buffer: RTL and testbench
====================================

Name: pipe_trace_buffer

Overview:
Synthesizable on-chip trace buffer for the PA-RISC pipeline. It snapshots one instruction word plus per-stage control-signal vectors (ID/EX/MEM/WB) into a circular RAM on every pipeline advance. Capture stops a programmable number of samples after an opcode/mask trigger, and the frozen history is then read out oldest-first. It replaces cycle-by-cycle simulation printing with hardware that also works post-synthesis and on FPGA.

Parameters:
WIDTH, 16, width of each stage's control-signal vector
STAGES, 4, number of pipeline stages captured (ID, EX, MEM, WB)
DEPTH, 16, trace entries; power of two, >= 2
AW, 4, log2(DEPTH); pointer width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
arm  in  1  pulse: clear buffer, enter ARMED
sample_en  in  1  pipeline advanced this cycle; capture one entry
inst  in  32  instruction word in decode (InstructionOut)
stage_data  in  STAGES*WIDTH  concatenated stage control vectors; stage 0 in LSBs
trig_value  in  32  trigger compare value
trig_mask  in  32  trigger compare mask; 1 = bit compared
post_count  in  AW  samples captured after the trigger entry
rd_en  in  1  read request (FROZEN only)
rd_data  out  32+STAGES*WIDTH  {inst, stage_data} of the entry read
rd_valid  out  1  rd_data valid this cycle
state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 FROZEN
triggered  out  1  trigger has fired since the last arm
trig_index  out  AW  read-order position of the trigger entry (0 = oldest)
count  out  AW+1  valid entries, saturates at DEPTH
rd_done  out  1  all count entries have been read

Behaviour:
- Reset: state=IDLE, wr_ptr=0, rd_ptr=0, count=0, remaining=0, rd_data=0, rd_valid=0, triggered=0, trig_index=0, rd_done=0. RAM contents are not reset. Reset wins over every other input.
- arm (any state): wr_ptr, count, triggered, rd_done, remaining are cleared; state becomes ARMED next cycle. A sample_en in the same cycle is ignored. arm has priority over rd_en.
- IDLE: sample_en and rd_en are ignored.
- ARMED, sample_en=1:
  - Write {inst, stage_data} at wr_ptr.
  - wr_ptr increments mod DEPTH; count increments and saturates at DEPTH.
  - Trigger condition: ((inst ^ trig_value) & trig_mask) == 0.
  - On trigger, this entry is written and triggered=1. Its physical index is recorded, and remaining = min(post_count, DEPTH-1).
  - Next state is FROZEN if remaining is 0, otherwise POST.
- POST, sample_en=1: write as in ARMED, then remaining decrements. The write made when remaining==1 moves state to FROZEN. Further trigger matches are ignored.
- Clamping post_count to DEPTH-1 guarantees the trigger entry is never overwritten.
- FROZEN:
  - On entry, rd_ptr = oldest entry: wr_ptr if count==DEPTH, else 0.
  - trig_index = (trigger physical index - oldest) mod DEPTH.
  - sample_en is ignored.
- Read: in FROZEN with rd_en=1 and fewer than count entries read, rd_data = RAM[rd_ptr] with rd_valid=1 on the next cycle (1-cycle latency), and rd_ptr increments mod DEPTH.
- After count reads, rd_done=1. Further rd_en gives rd_valid=0 and rd_data holds its last value.
- rd_en outside FROZEN: rd_valid=0.
- rd_valid is a single-cycle strobe per accepted read; back-to-back rd_en yields back-to-back data.
- Wrap-around: before the trigger, the buffer overwrites the oldest entry indefinitely; count stays at DEPTH.

Test Plan:
1. Reset, then idle 5 cycles with sample_en=1 -> state=00, count=0, rd_valid=0, triggered=0.
2. DEPTH=16; arm; trig_value=0x08000000, trig_mask=0xFC000000 (LDI). Feed 3 non-matching samples, then LDI, with post_count=2 and 2 more samples -> state=11, count=6, trig_index=3. 6 reads return the entries in feed order; rd_done=1; a 7th rd_en gives rd_valid=0.
3. Wrap: arm, feed 20 non-matching samples tagged 1..20, then a matching sample with post_count=0 -> count=16, reads return tags 6..20 then the trigger entry, trig_index=15.
4. post_count=15 with trigger on the first sample, then 30 samples -> freezes after 15 post samples, count=16, trig_index=0, and the trigger entry is still present.
5. Gapped sample_en (1,0,0,1) in POST -> only asserted cycles decrement remaining. In FROZEN, sample_en=1 with new data leaves count unchanged.
6. arm asserted mid-POST and mid-readout -> next cycle state=01, count=0, triggered=0, rd_done=0. Reset asserted mid-readout -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
// Circular trace RAM capturing {inst, stage_data} on each pipeline advance.
// Capture freezes a programmable number of samples after a masked opcode trigger.
module pipe_trace_buffer #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         sample_en,
    input  logic [31:0]                  inst,
    input  logic [STAGES*WIDTH-1:0]      stage_data,
    input  logic [31:0]                  trig_value,
    input  logic [31:0]                  trig_mask,
    input  logic [AW-1:0]                post_count,
    input  logic                         rd_en,
    output logic [32+STAGES*WIDTH-1:0]   rd_data,
    output logic                         rd_valid,
    output logic [1:0]                   state,
    output logic                         triggered,
    output logic [AW-1:0]                trig_index,
    output logic [AW:0]                  count,
    output logic                         rd_done
);

    localparam int DW = 32 + STAGES * WIDTH;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_POST   = 2'b10,
        S_FROZEN = 2'b11
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AW:0]       r_rd_cnt;
    logic [AW-1:0]     r_remaining;
    logic [AW-1:0]     r_trig_phys;
    logic [AW-1:0]     r_trig_index;
    logic              r_triggered;
    logic              r_rd_done;
    logic              r_rd_valid;
    logic [DW-1:0]     r_rd_data;
    logic [DW-1:0]     r_mem [DEPTH];

    logic [31:0]       w_bit_hit;
    logic              w_match;
    logic              w_capture;
    logic              w_fire;
    logic              w_freeze;
    logic              w_rd_accept;
    logic [AW-1:0]     w_wr_ptr_inc;
    logic [AW:0]       w_count_inc;
    logic [AW-1:0]     w_oldest;
    logic [AW-1:0]     w_freeze_phys;

    // A bit hits when it is masked out or equals the compare value.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_trig_bit
            assign w_bit_hit[gi] = ~trig_mask[gi] | ~(inst[gi] ^ trig_value[gi]);
        end
    endgenerate

    assign w_match       = &w_bit_hit;
    assign w_capture     = !reset && !arm && sample_en &&
                           ((r_state == S_ARMED) || (r_state == S_POST));
    assign w_fire        = w_capture && (r_state == S_ARMED) && w_match;
    // post_count is AW bits wide, so it never exceeds DEPTH-1 and the
    // trigger entry cannot be overwritten before the freeze.
    assign w_freeze      = (w_fire && (post_count == '0)) ||
                           (w_capture && (r_state == S_POST) && (r_remaining == PTR_ONE));
    assign w_wr_ptr_inc  = r_wr_ptr + PTR_ONE;
    assign w_count_inc   = (r_count == CNT_FULL) ? r_count : (r_count + CNT_ONE);
    assign w_oldest      = (w_count_inc == CNT_FULL) ? w_wr_ptr_inc : '0;
    assign w_freeze_phys = (r_state == S_ARMED) ? r_wr_ptr : r_trig_phys;
    assign w_rd_accept   = !reset && !arm && rd_en && (r_state == S_FROZEN) &&
                           (r_rd_cnt < r_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_cnt     <= '0;
            r_remaining  <= '0;
            r_trig_phys  <= '0;
            r_trig_index <= '0;
            r_triggered  <= 1'b0;
            r_rd_done    <= 1'b0;
            r_rd_valid   <= 1'b0;
        end else if (arm) begin
            r_state      <= S_ARMED;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_rd_cnt     <= '0;
            r_remaining  <= '0;
            r_triggered  <= 1'b0;
            r_rd_done    <= 1'b0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;

            if (w_capture) begin
                r_wr_ptr <= w_wr_ptr_inc;
                r_count  <= w_count_inc;
            end

            if (w_fire) begin
                r_triggered <= 1'b1;
                r_trig_phys <= r_wr_ptr;
                r_remaining <= post_count;
                r_state     <= S_POST;
            end else if (w_capture && (r_state == S_POST)) begin
                r_remaining <= r_remaining - PTR_ONE;
            end

            // Freeze overrides the POST transition above when no post samples remain.
            if (w_freeze) begin
                r_state      <= S_FROZEN;
                r_rd_ptr     <= w_oldest;
                r_trig_index <= w_freeze_phys - w_oldest;
                r_rd_cnt     <= '0;
            end

            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_rd_cnt <= r_rd_cnt + CNT_ONE;
                if ((r_rd_cnt + CNT_ONE) == r_count) begin
                    r_rd_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= {inst, stage_data};
        end
    end

    // Registered read port; holds its last value once the readout is done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_rd_accept) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign state      = r_state;
    assign triggered  = r_triggered;
    assign trig_index = r_trig_index;
    assign count      = r_count;
    assign rd_done    = r_rd_done;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: a queue holds the entries expected to be
// resident in the trace RAM and is popped as the frozen history is read back.
module tb_pipe_trace_buffer;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int DW     = 32 + STAGES * WIDTH;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      arm;
    logic                      sample_en;
    logic [31:0]               inst;
    logic [STAGES*WIDTH-1:0]   stage_data;
    logic [31:0]               trig_value;
    logic [31:0]               trig_mask;
    logic [AW-1:0]             post_count;
    logic                      rd_en;
    logic [DW-1:0]             rd_data;
    logic                      rd_valid;
    logic [1:0]                state;
    logic                      triggered;
    logic [AW-1:0]             trig_index;
    logic [AW:0]               count;
    logic                      rd_done;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd;

    pipe_trace_buffer #(
        .WIDTH(WIDTH), .STAGES(STAGES), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .sample_en(sample_en),
        .inst(inst), .stage_data(stage_data), .trig_value(trig_value),
        .trig_mask(trig_mask), .post_count(post_count), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .state(state),
        .triggered(triggered), .trig_index(trig_index), .count(count),
        .rd_done(rd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ninst(input int tag);
        return 32'h0400_0000 | 32'(tag);
    endfunction

    function automatic logic [31:0] ldi(input int tag);
        return 32'h0800_0000 | 32'(tag);
    endfunction

    function automatic logic [STAGES*WIDTH-1:0] mk_sd(input int tag);
        return {16'(tag + 300), 16'(tag + 200), 16'(tag + 100), 16'(tag)};
    endfunction

    // capt: the bench expects this sample to land in the trace RAM.
    task automatic feed(input logic [31:0] ins, input int tag, input bit capt);
        inst       = ins;
        stage_data = mk_sd(tag);
        sample_en  = 1'b1;
        tick();
        sample_en  = 1'b0;
        if (capt) begin
            exp_q.push_back({ins, mk_sd(tag)});
            if (exp_q.size() > DEPTH) exp_q.delete(0);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        exp_q.delete();
    endtask

    task automatic read_n(input int n, input string tag);
        logic [DW-1:0] e;
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s_valid%0d", tag, i), DW'(rd_valid), DW'(1));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_underflow%0d observed=%0h expected=none", tag, i, rd_data);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_data%0d", tag, i), rd_data, e);
            end
            last_rd = rd_data;
            $display("read %s[%0d] data=%h valid=%0d", tag, i, rd_data, rd_valid);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; sample_en = 1'b0; rd_en = 1'b0;
        inst = '0; stage_data = '0; post_count = '0;
        trig_value = 32'h0800_0000; trig_mask = 32'hFC00_0000;
        last_rd = '0;
        tick(); tick();
        reset = 1'b0;

        // 1: IDLE ignores sample_en and rd_en
        sample_en = 1'b1; rd_en = 1'b1; inst = ldi(1); stage_data = mk_sd(1);
        for (int i = 0; i < 5; i++) tick();
        sample_en = 1'b0; rd_en = 1'b0;
        check("t1_state", DW'(state), DW'(0));
        check("t1_count", DW'(count), DW'(0));
        check("t1_rd_valid", DW'(rd_valid), DW'(0));
        check("t1_triggered", DW'(triggered), DW'(0));
        check("t1_rd_data", rd_data, '0);

        // 2: LDI trigger with two post samples
        do_arm();
        check("t2_armed", DW'(state), DW'(1));
        post_count = 4'd2;
        feed(ninst(1), 1, 1'b1);
        feed(ninst(2), 2, 1'b1);
        feed(ninst(3), 3, 1'b1);
        check("t2_pre_trig", DW'(triggered), DW'(0));
        feed(ldi(4), 4, 1'b1);
        check("t2_post_state", DW'(state), DW'(2));
        check("t2_triggered", DW'(triggered), DW'(1));
        feed(ninst(5), 5, 1'b1);
        feed(ninst(6), 6, 1'b1);
        check("t2_frozen", DW'(state), DW'(3));
        check("t2_count", DW'(count), DW'(6));
        check("t2_trig_index", DW'(trig_index), DW'(3));
        read_n(5, "t2");
        check("t2_done_early", DW'(rd_done), DW'(0));
        read_n(1, "t2b");
        check("t2_done", DW'(rd_done), DW'(1));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t2_extra_valid", DW'(rd_valid), DW'(0));
        check("t2_extra_hold", rd_data, last_rd);

        // 3: wrap-around before trigger, no post samples
        do_arm();
        post_count = 4'd0;
        for (int t = 1; t <= 20; t++) feed(ninst(t), t, 1'b1);
        check("t3_armed", DW'(state), DW'(1));
        check("t3_count_sat", DW'(count), DW'(16));
        feed(ldi(21), 21, 1'b1);
        check("t3_frozen", DW'(state), DW'(3));
        check("t3_count", DW'(count), DW'(16));
        check("t3_trig_index", DW'(trig_index), DW'(15));
        read_n(16, "t3");
        check("t3_done", DW'(rd_done), DW'(1));

        // 4: maximum post_count, trigger on first sample; later matches ignored
        do_arm();
        post_count = 4'd15;
        feed(ldi(1), 1, 1'b1);
        for (int t = 2; t <= 31; t++)
            feed((t % 5 == 0) ? ldi(t) : ninst(t), t, (t <= 16));
        check("t4_frozen", DW'(state), DW'(3));
        check("t4_count", DW'(count), DW'(16));
        check("t4_trig_index", DW'(trig_index), DW'(0));
        read_n(16, "t4");

        // 5: gapped sample_en in POST; FROZEN ignores samples
        do_arm();
        post_count = 4'd3;
        feed(ldi(1), 1, 1'b1);
        feed(ninst(2), 2, 1'b1);
        tick(); tick();
        feed(ninst(3), 3, 1'b1);
        check("t5_still_post", DW'(state), DW'(2));
        feed(ninst(4), 4, 1'b1);
        check("t5_frozen", DW'(state), DW'(3));
        check("t5_count", DW'(count), DW'(4));
        feed(ninst(50), 50, 1'b0);
        check("t5_count_frozen", DW'(count), DW'(4));
        read_n(4, "t5");

        // 6a: arm mid-POST
        do_arm();
        post_count = 4'd5;
        feed(ldi(1), 1, 1'b1);
        feed(ninst(2), 2, 1'b1);
        check("t6a_post", DW'(state), DW'(2));
        do_arm();
        check("t6a_state", DW'(state), DW'(1));
        check("t6a_count", DW'(count), DW'(0));
        check("t6a_triggered", DW'(triggered), DW'(0));

        // 6b: arm after a complete readout clears rd_done
        post_count = 4'd0;
        feed(ninst(1), 1, 1'b1);
        feed(ldi(2), 2, 1'b1);
        read_n(2, "t6b");
        check("t6b_done", DW'(rd_done), DW'(1));
        do_arm();
        check("t6b_state", DW'(state), DW'(1));
        check("t6b_count", DW'(count), DW'(0));
        check("t6b_triggered", DW'(triggered), DW'(0));
        check("t6b_rd_done", DW'(rd_done), DW'(0));

        // 6c: reset mid-readout, with rd_en held high
        feed(ninst(1), 1, 1'b1);
        feed(ninst(2), 2, 1'b1);
        feed(ldi(3), 3, 1'b1);
        check("t6c_trig_index", DW'(trig_index), DW'(2));
        read_n(1, "t6c");
        reset = 1'b1; rd_en = 1'b1;
        tick();
        reset = 1'b0; rd_en = 1'b0;
        exp_q.delete();
        check("t6c_state", DW'(state), DW'(0));
        check("t6c_count", DW'(count), DW'(0));
        check("t6c_rd_valid", DW'(rd_valid), DW'(0));
        check("t6c_triggered", DW'(triggered), DW'(0));
        check("t6c_trig_index0", DW'(trig_index), DW'(0));
        check("t6c_rd_done", DW'(rd_done), DW'(0));
        check("t6c_rd_data", rd_data, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
